data_sram_bridge: RTL and testbench

- Sits directly downstream of the store byte-enable/data-replication stage in the MEM stage of the MIPS pipeline.
- Converts each single-cycle MEM-stage access into a sram-like handshake toward the AXI interface. The handshake is a request phase (addr_ok) followed by a data phase (data_ok).
- Stalls the pipeline until the access completes and holds read data until the pipeline advances.
- Suppresses any access that carries an exception, such as an address-error store or load.

---
 rtl/data_sram_bridge.sv | 127 ++++++++++++
 tb/tb_data_sram_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// MEM-stage to sram-like bridge: turns one pipeline load/store into a request/data handshake,
// stalls the pipeline until completion and holds load data until the pipeline advances.
module data_sram_bridge #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_except,
  input  logic        ext_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state_reg, state_next;
  logic        start;
  logic        capture;
  logic [31:0] paddr;
  logic [31:0] addr_next;
  logic [1:0]  size_next;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;

  assign start = mem_en & ~mem_except;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB
  always_comb begin
    paddr = mem_addr;
    if (KSEG_MAP && (mem_addr[31:29] == 3'b100 || mem_addr[31:29] == 3'b101))
      paddr = {3'b000, mem_addr[28:0]};
  end

  always_comb begin
    size_next = 2'd2;
    case (mem_we)
      4'b1111:                         size_next = 2'd2;
      4'b0011, 4'b1100:                size_next = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_next = 2'd0;
      default:                         size_next = 2'd2;
    endcase
  end

  // loads always fetch the whole word; the load-extract stage picks the bytes
  assign addr_next = (mem_we == 4'b0000) ? {paddr[31:2], 2'b00} : paddr;

  always_comb begin
    state_next = state_reg;
    mem_stall  = 1'b0;
    data_req   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_stall = start;
        if (start) state_next = ADDR;
      end
      ADDR: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (data_addr_ok) begin
          state_next = DATA;
        end
      end
      DATA: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!ext_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else if (state_reg == IDLE && start) begin
      wr_reg    <= |mem_we;
      size_reg  <= size_next;
      addr_reg  <= addr_next;
      wdata_reg <= mem_wdata;
    end
  end

  // store completions leave the last load word untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    rdata_reg <= 32'd0;
    else if (capture && !wr_reg) rdata_reg <= data_rdata;
  end

  assign data_wr    = wr_reg;
  assign data_size  = size_reg;
  assign data_addr  = addr_reg;
  assign data_wdata = wdata_reg;
  assign mem_rdata  = rdata_reg;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: table of accesses driven through a small slave model,
// plus hand sequences for DONE hold under ext_stall and asynchronous reset mid-access.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_except, ext_stall;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] mem_rdata, data_addr, data_wdata;
  logic        mem_stall, data_req, data_wr;
  logic [1:0]  data_size;

  logic [31:0] mem_rdata1, data_addr1, data_wdata1;
  logic        mem_stall1, data_req1, data_wr1;
  logic [1:0]  data_size1;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  data_sram_bridge #(.KSEG_MAP(1'b1)) u0 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_except(mem_except), .ext_stall(ext_stall),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata));

  data_sram_bridge #(.KSEG_MAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_except(mem_except), .ext_stall(ext_stall),
    .mem_rdata(mem_rdata1), .mem_stall(mem_stall1), .data_req(data_req1), .data_wr(data_wr1),
    .data_size(data_size1), .data_addr(data_addr1), .data_wdata(data_wdata1),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata));

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exc;
    int          aw;      // extra ADDR cycles before addr_ok
    int          dw;      // DATA cycles until data_ok (0: together with addr_ok)
    logic [31:0] rdata;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr;
    logic [31:0] exp_addr1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // entered exactly at a negedge; returns at a negedge
  task automatic run_vec(input int idx, input vec_t v, input bit hold_en);
    int  stall_cnt = 0;
    int  req_cnt = 0;
    int  dcnt = 0;
    bit  accepted = 0;
    bit  done = 0;
    mem_en = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_except = v.exc;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (v.exc && i >= 5) done = 1;
      else if (!v.exc && !mem_stall) done = 1;
      else begin
        if (mem_stall) stall_cnt++;
        if (data_req) begin
          req_cnt++;
          chk($sformatf("v%0d_wr", idx), {31'd0, data_wr}, {31'd0, v.exp_wr});
          chk($sformatf("v%0d_size", idx), {30'd0, data_size}, {30'd0, v.exp_size});
          chk($sformatf("v%0d_addr", idx), data_addr, v.exp_addr);
          chk($sformatf("v%0d_wdata", idx), data_wdata, v.wdata);
          chk($sformatf("v%0d_addr_nomap", idx), data_addr1, v.exp_addr1);
          if (req_cnt == v.aw + 1) begin
            data_addr_ok = 1'b1;
            if (v.dw == 0) begin
              data_data_ok = 1'b1;
              data_rdata = v.rdata;
            end else accepted = 1;
          end
        end else if (accepted) begin
          dcnt++;
          if (dcnt == v.dw) begin
            data_data_ok = 1'b1;
            data_rdata = v.rdata;
          end
        end
        @(negedge clk);
      end
    end
    chk($sformatf("v%0d_timeout", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exc ? 0 : 2 + v.aw + v.dw);
    chk($sformatf("v%0d_req_cycles", idx), req_cnt, v.exc ? 0 : v.aw + 1);
    if (!v.exc && v.we == 4'b0000) last_load = v.rdata;
    if (!v.exc && (v.we == 4'b0000 || v.dw > 0))
      chk($sformatf("v%0d_rdata", idx), mem_rdata, last_load);
    if (!hold_en) mem_en = 1'b0;
    mem_except = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t lw;
    rst = 1'b1; mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_except = 0;
    ext_stall = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;

    vecs[0] = '{4'hF, 32'h8000_0010, 32'h1234_5678, 1'b0, 0, 0, 32'h0, 1'b1, 2'd2, 32'h0000_0010, 32'h8000_0010};
    vecs[1] = '{4'h8, 32'hBFC0_0003, 32'hABAB_ABAB, 1'b0, 2, 2, 32'h0, 1'b1, 2'd0, 32'h1FC0_0003, 32'hBFC0_0003};
    vecs[2] = '{4'h3, 32'hA000_1002, 32'hBEEF_BEEF, 1'b0, 1, 0, 32'h0, 1'b1, 2'd1, 32'h0000_1002, 32'hA000_1002};
    vecs[3] = '{4'h0, 32'h0040_0006, 32'h0, 1'b0, 0, 1, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0040_0004, 32'h0040_0004};
    vecs[4] = '{4'h5, 32'h0000_0020, 32'h1122_3344, 1'b0, 0, 0, 32'h0, 1'b1, 2'd2, 32'h0000_0020, 32'h0000_0020};
    vecs[5] = '{4'hF, 32'h0000_0003, 32'h5555_AAAA, 1'b1, 0, 0, 32'h0, 1'b1, 2'd2, 32'h0, 32'h0};
    vecs[6] = '{4'h0, 32'h8000_0103, 32'h0, 1'b0, 1, 2, 32'hCAFE_F00D, 1'b0, 2'd2, 32'h0000_0100, 32'h8000_0100};
    vecs[7] = '{4'hC, 32'hC000_0002, 32'h7788_7788, 1'b0, 1, 3, 32'h0, 1'b1, 2'd1, 32'hC000_0002, 32'hC000_0002};

    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i], 1'b0);

    // load completes, then ext_stall holds DONE with mem_en still asserted
    lw = '{4'h0, 32'h0040_0006, 32'h0, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0, 2'd2, 32'h0040_0004, 32'h0040_0004};
    ext_stall = 1'b1;
    run_vec(8, lw, 1'b1);
    data_rdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d_req", k), {31'd0, data_req}, 32'd0);
      chk($sformatf("hold%0d_stall", k), {31'd0, mem_stall}, 32'd0);
      chk($sformatf("hold%0d_rdata", k), mem_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    ext_stall = 1'b0; mem_en = 1'b0;
    @(negedge clk); #1;
    chk("after_hold_req", {31'd0, data_req}, 32'd0);
    chk("after_hold_rdata", mem_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // asynchronous reset while in DATA
    mem_en = 1'b1; mem_we = 4'h0; mem_addr = 32'h0000_0040; mem_wdata = 32'h0;
    @(negedge clk); #1;
    chk("rstseq_addr_req", {31'd0, data_req}, 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk); #1;
    data_addr_ok = 1'b0;
    mem_en = 1'b0;
    chk("rstseq_data_req", {31'd0, data_req}, 32'd0);
    chk("rstseq_data_stall", {31'd0, mem_stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_stall", {31'd0, mem_stall}, 32'd0);
    chk("async_req", {31'd0, data_req}, 32'd0);
    chk("async_wr_size", {29'd0, data_wr, data_size}, 32'd0);
    chk("async_addr", data_addr, 32'd0);
    chk("async_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    @(negedge clk); #1;
    data_data_ok = 1'b0;
    chk("late_ok_rdata", mem_rdata, 32'd0);
    chk("late_ok_stall", {31'd0, mem_stall}, 32'd0);
    chk("late_ok_req", {31'd0, data_req}, 32'd0);
    @(negedge clk);
    last_load = 32'd0;
    run_vec(9, vecs[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
